lfsr_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random source: the next-generation 28-bit XNOR LFSR.

---
 rtl/lfsr_pkg.sv | 55 +++++
 rtl/lfsr_next_comb.sv | 33 +++
 rtl/lfsr_gen.sv | 139 +++++++++++++
 tb/tb_lfsr_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared helpers for the Fibonacci LFSR family: single-shift function,
// lock-up value, tap sanity check and the update-kind enum used by lfsr_gen.
package lfsr_pkg;

  // Widest LFSR these helpers can describe; narrower LFSRs live in the low bits.
  localparam int LFSR_MAX_W = 64;

  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  // What the state/start/count registers do on a given clock edge.
  typedef enum logic [2:0] {
    UPD_HOLD   = 3'd0,
    UPD_PRIME  = 3'd1,
    UPD_ADV    = 3'd2,
    UPD_LOAD   = 3'd3,
    UPD_LOCKUP = 3'd4
  } upd_e;

  // Mask covering the low 'width' bits of a word.
  function automatic lfsr_word_t width_mask(input int width);
    if (width >= LFSR_MAX_W) begin
      return '1;
    end
    return (lfsr_word_t'(1) << width) - lfsr_word_t'(1);
  endfunction

  // One Fibonacci shift: the parity (or inverted parity) of the tapped bits
  // enters at bit 0 and everything moves one place towards the MSB.
  function automatic lfsr_word_t lfsr_shift(input lfsr_word_t state,
                                            input lfsr_word_t taps,
                                            input int         width,
                                            input logic       use_xnor);
    lfsr_word_t mask;
    logic       fb;
    mask = width_mask(width);
    fb   = (^(state & taps & mask)) ^ use_xnor;
    return ((state << 1) & mask) | {{(LFSR_MAX_W-1){1'b0}}, fb};
  endfunction

  // The single state an LFSR can never leave: all ones for XNOR feedback,
  // all zeros for XOR feedback.
  function automatic lfsr_word_t lockup_val(input int width, input logic use_xnor);
    return use_xnor ? width_mask(width) : '0;
  endfunction

  // The MSB tap must be present, and no tap may sit above the state width.
  function automatic logic taps_ok(input lfsr_word_t taps, input int width);
    logic msb_set;
    logic no_extra;
    msb_set  = taps[width-1];
    no_extra = ((taps & ~width_mask(width)) == '0);
    return msb_set & no_extra;
  endfunction

endpackage

// File: rtl/lfsr_next_comb.sv
// Combinational STEP-fold of lfsr_shift: returns the state reached after
// STEP consecutive single shifts. Shared with the LFSR checker block.
module lfsr_next_comb
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 28,
  parameter logic [WIDTH-1:0] TAPS     = 28'h8810001,
  parameter bit               USE_XNOR = 1'b1,
  parameter int               STEP     = 1
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  localparam lfsr_word_t TAP_EXT = lfsr_word_t'(TAPS);

  lfsr_word_t w_acc;
  logic       w_unusedHi;

  // Unrolled chain of STEP single shifts on a zero-extended copy of the state.
  always_comb begin
    w_acc = '0;
    w_acc[WIDTH-1:0] = i_state;
    for (int k = 0; k < STEP; k++) begin
      w_acc = lfsr_shift(w_acc, TAP_EXT, WIDTH, USE_XNOR);
    end
    o_next = w_acc[WIDTH-1:0];
  end

  // Bits above WIDTH are always masked to zero by lfsr_shift.
  assign w_unusedHi = ^w_acc[LFSR_MAX_W-1:WIDTH];

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR word source with seed load, lock-up rejection,
// valid/ready output handshake, advance counter, wrap and period pulses.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 28,
  parameter logic [WIDTH-1:0] TAPS     = 28'h8810001,
  parameter bit               USE_XNOR = 1'b1,
  parameter int               STEP     = 1,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [CNT_W-1:0] steps,
  output logic             wrap,
  output logic             period_done,
  output logic             lockup
);

  localparam lfsr_word_t       LOCKUP_EXT = lockup_val(WIDTH, USE_XNOR);
  localparam logic [WIDTH-1:0] LOCKUP     = LOCKUP_EXT[WIDTH-1:0];
  localparam bit               SEED_OK    = (SEED != LOCKUP);
  localparam bit               WIDTH_OK   = (WIDTH >= 3) && (WIDTH < LFSR_MAX_W);
  localparam bit               STEP_OK    = (STEP >= 1) && (STEP <= WIDTH - 1);
  localparam bit               TAPS_GOOD  = taps_ok(lfsr_word_t'(TAPS), WIDTH);

  // Reject configurations that would produce a stuck or ill-formed sequence.
  generate
    if (!WIDTH_OK) begin : g_badWidth
      $error("lfsr_gen: WIDTH must be at least 3 and below LFSR_MAX_W");
    end
    if (!STEP_OK) begin : g_badStep
      $error("lfsr_gen: STEP must lie in 1..WIDTH-1");
    end
    if (!TAPS_GOOD) begin : g_badTaps
      $error("lfsr_gen: TAPS must have bit WIDTH-1 set and nothing above it");
    end
    if (!SEED_OK) begin : g_badSeed
      $error("lfsr_gen: SEED equals the lock-up value");
    end
  endgenerate

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic [CNT_W-1:0] r_steps;
  logic             r_valid;
  logic             r_wrap;
  logic             r_period;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic             w_adv;
  logic             w_seedLocked;
  upd_e             w_upd;

  lfsr_next_comb #(
    .WIDTH   (WIDTH),
    .TAPS    (TAPS),
    .USE_XNOR(USE_XNOR),
    .STEP    (STEP)
  ) u_next (
    .i_state(r_state),
    .o_next (w_next)
  );

  // A word is consumed when enabled, presented and accepted; a load takes precedence.
  assign w_adv        = en & r_valid & out_ready & ~load;
  assign w_seedLocked = (seed == LOCKUP);

  // Decide which single update the registers perform this cycle.
  always_comb begin
    w_upd = UPD_HOLD;
    if (load) begin
      w_upd = w_seedLocked ? UPD_LOCKUP : UPD_LOAD;
    end else if (w_adv) begin
      w_upd = UPD_ADV;
    end else if (!r_valid) begin
      w_upd = UPD_PRIME;
    end
  end

  // State, start point, counter, handshake flag and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEED;
      r_start  <= SEED;
      r_steps  <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_period <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_period <= 1'b0;
      r_lockup <= 1'b0;
      case (w_upd)
        UPD_PRIME: begin
          r_valid <= 1'b1;
        end
        UPD_ADV: begin
          r_state  <= w_next;
          r_steps  <= r_steps + CNT_W'(1);
          r_wrap   <= (r_steps == '1);
          r_period <= (w_next == r_start);
        end
        UPD_LOAD: begin
          r_state <= seed;
          r_start <= seed;
          r_steps <= '0;
          r_valid <= 1'b1;
        end
        UPD_LOCKUP: begin
          r_state  <= SEED;
          r_start  <= SEED;
          r_steps  <= '0;
          r_valid  <= 1'b1;
          r_lockup <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign lfsr_out    = r_state;
  assign steps       = r_steps;
  assign wrap        = r_wrap;
  assign period_done = r_period;
  assign lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: three instances (default, STEP=2,
// 4-bit) driven by directed sequences and random traffic, compared every
// cycle with an arithmetic reference model.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst = 3'b000;
  logic [2:0]  en  = 3'b000;
  logic [2:0]  ld  = 3'b000;
  logic [2:0]  rdy = 3'b000;
  logic [27:0] sd[3];

  logic [27:0] outA, outB;
  logic [3:0]  outC;
  logic [31:0] stepsA, stepsB;
  logic [3:0]  stepsC;
  logic [2:0]  vld, wrp, prd, lck;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned state;
    longint unsigned start;
    longint unsigned steps;
    bit              valid;
    bit              wrap;
    bit              period;
    bit              lockup;
  } modelT;

  modelT           mdl[3];
  int              cfgWidth[3] = '{28, 28, 4};
  int              cfgStep[3]  = '{1, 2, 1};
  int              cfgCntw[3]  = '{32, 32, 4};
  longint unsigned cfgTaps[3]  = '{64'h8810001, 64'h8810001, 64'hC};

  lfsr_gen u_dutA (
    .clk(clk), .reset(rst[0]), .en(en[0]), .load(ld[0]), .seed(sd[0]),
    .out_ready(rdy[0]), .out_valid(vld[0]), .lfsr_out(outA), .steps(stepsA),
    .wrap(wrp[0]), .period_done(prd[0]), .lockup(lck[0])
  );

  lfsr_gen #(.STEP(2)) u_dutB (
    .clk(clk), .reset(rst[1]), .en(en[1]), .load(ld[1]), .seed(sd[1]),
    .out_ready(rdy[1]), .out_valid(vld[1]), .lfsr_out(outB), .steps(stepsB),
    .wrap(wrp[1]), .period_done(prd[1]), .lockup(lck[1])
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .USE_XNOR(1'b1), .STEP(1), .SEED(4'h0), .CNT_W(4)) u_dutC (
    .clk(clk), .reset(rst[2]), .en(en[2]), .load(ld[2]), .seed(sd[2][3:0]),
    .out_ready(rdy[2]), .out_valid(vld[2]), .lfsr_out(outC), .steps(stepsC),
    .wrap(wrp[2]), .period_done(prd[2]), .lockup(lck[2])
  );

  // Reference single shift: XNOR feedback is the even-parity flag of the tapped bits.
  function automatic longint unsigned refShift(longint unsigned s, int i);
    longint unsigned fb;
    fb = (($countones(s & cfgTaps[i]) % 2) == 0) ? 1 : 0;
    return (s * 2 + fb) % (64'd1 << cfgWidth[i]);
  endfunction

  function automatic modelT modelReset();
    modelT m;
    m.state  = 0;
    m.start  = 0;
    m.steps  = 0;
    m.valid  = 1'b0;
    m.wrap   = 1'b0;
    m.period = 1'b0;
    m.lockup = 1'b0;
    return m;
  endfunction

  // One clock edge of the behavioural model, given the inputs seen at that edge.
  function automatic modelT modelNext(modelT m, int i, bit e, bit l, bit r, longint unsigned seedIn);
    modelT           n;
    longint unsigned s;
    longint unsigned allOnes;
    n        = m;
    n.wrap   = 1'b0;
    n.period = 1'b0;
    n.lockup = 1'b0;
    n.valid  = 1'b1;
    allOnes  = (64'd1 << cfgWidth[i]) - 1;
    if (l) begin
      n.steps = 0;
      if (seedIn == allOnes) begin
        n.state  = 0;
        n.start  = 0;
        n.lockup = 1'b1;
      end else begin
        n.state = seedIn;
        n.start = seedIn;
      end
    end else if (e && m.valid && r) begin
      s = m.state;
      for (int k = 0; k < cfgStep[i]; k++) s = refShift(s, i);
      n.state  = s;
      n.wrap   = (m.steps == (64'd1 << cfgCntw[i]) - 1);
      n.steps  = (m.steps + 1) % (64'd1 << cfgCntw[i]);
      n.period = (s == m.start);
    end
    return n;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkInst(int i);
    logic [63:0] gotOut;
    logic [63:0] gotSteps;
    case (i)
      0:       begin gotOut = 64'(outA); gotSteps = 64'(stepsA); end
      1:       begin gotOut = 64'(outB); gotSteps = 64'(stepsB); end
      default: begin gotOut = 64'(outC); gotSteps = 64'(stepsC); end
    endcase
    checkOutput($sformatf("u%0d.lfsr_out", i), gotOut, mdl[i].state);
    checkOutput($sformatf("u%0d.steps", i), gotSteps, mdl[i].steps);
    checkOutput($sformatf("u%0d.out_valid", i), 64'(vld[i]), 64'(mdl[i].valid));
    checkOutput($sformatf("u%0d.wrap", i), 64'(wrp[i]), 64'(mdl[i].wrap));
    checkOutput($sformatf("u%0d.period_done", i), 64'(prd[i]), 64'(mdl[i].period));
    checkOutput($sformatf("u%0d.lockup", i), 64'(lck[i]), 64'(mdl[i].lockup));
  endtask

  // Run n clocks with the current inputs, stepping the models and checking at each falling edge.
  task automatic applyStimulus(int n);
    repeat (n) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++)
        mdl[i] = modelNext(mdl[i], i, en[i], ld[i], rdy[i], 64'(sd[i]));
      @(negedge clk);
      for (int i = 0; i < 3; i++) checkInst(i);
    end
  endtask

  // Assert reset between edges, check the asynchronous effect, release on a falling edge.
  task automatic applyReset();
    rst = 3'b111;
    #1;
    for (int i = 0; i < 3; i++) begin
      mdl[i] = modelReset();
      checkInst(i);
    end
    @(negedge clk);
    rst = 3'b000;
    for (int i = 0; i < 3; i++) checkInst(i);
  endtask

  bit [15:0] seen;

  initial begin
    for (int i = 0; i < 3; i++) sd[i] = '0;
    applyReset();

    $display("[TB] basic sequence");
    en[0] = 1'b1; rdy[0] = 1'b1;
    applyStimulus(5);
    checkOutput("t1 out at 4th advance", 64'(outA), 64'hA);
    checkOutput("t1 steps at 4th advance", 64'(stepsA), 64'd4);

    $display("[TB] backpressure hold");
    applyReset();
    applyStimulus(3);
    rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput("t2 ready hold out", 64'(outA), 64'h2);
      checkOutput("t2 ready hold steps", 64'(stepsA), 64'd2);
    end
    rdy[0] = 1'b1;
    applyStimulus(1);
    checkOutput("t2 ready release out", 64'(outA), 64'h5);
    applyReset();
    applyStimulus(3);
    en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput("t2 en hold out", 64'(outA), 64'h2);
      checkOutput("t2 en hold steps", 64'(stepsA), 64'd2);
    end
    en[0] = 1'b1;
    applyStimulus(1);
    checkOutput("t2 en release out", 64'(outA), 64'h5);

    $display("[TB] seed load and lock-up");
    ld[0] = 1'b1; sd[0] = 28'hFFFFFFF;
    applyStimulus(1);
    checkOutput("t3 lockup pulse", 64'(lck[0]), 64'd1);
    checkOutput("t3 lockup out", 64'(outA), 64'h0);
    checkOutput("t3 lockup steps", 64'(stepsA), 64'd0);
    sd[0] = 28'h123;
    applyStimulus(1);
    checkOutput("t3 load out", 64'(outA), 64'h123);
    checkOutput("t3 load no pulse", 64'(lck[0]), 64'd0);
    ld[0] = 1'b0;

    $display("[TB] two shifts per advance");
    applyReset();
    en[1] = 1'b1; rdy[1] = 1'b1;
    applyStimulus(2);
    checkOutput("t4 first word", 64'(outB), 64'h2);
    applyStimulus(1);
    checkOutput("t4 second word", 64'(outB), 64'hA);

    $display("[TB] 4-bit full period");
    applyReset();
    en = 3'b100; rdy = 3'b100;
    applyStimulus(1);
    seen = '0;
    seen[outC] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1);
      if (k < 15) begin
        seen[outC] = 1'b1;
        checkOutput("t5 early period", 64'(prd[2]), 64'd0);
      end
    end
    checkOutput("t5 period after 15", 64'(prd[2]), 64'd1);
    checkOutput("t5 steps after 15", 64'(stepsC), 64'd15);
    checkOutput("t5 distinct states", 64'($countones(seen)), 64'd15);
    checkOutput("t5 lock-up state visited", 64'(seen[15]), 64'd0);
    applyStimulus(1);
    checkOutput("t5 wrap after 16", 64'(wrp[2]), 64'd1);
    checkOutput("t5 steps after 16", 64'(stepsC), 64'd0);

    $display("[TB] random traffic");
    applyReset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        en[i]  = ($urandom % 4) != 0;
        rdy[i] = ($urandom % 3) != 0;
        ld[i]  = ($urandom % 24) == 0;
        if (($urandom % 4) == 0) sd[i] = (i == 2) ? 28'hF : 28'hFFFFFFF;
        else                     sd[i] = (i == 2) ? 28'($urandom_range(0, 15)) : 28'($urandom);
      end
      applyStimulus(1);
    end
    ld = 3'b000;

    $display("[TB] asynchronous reset mid-stream");
    en[0] = 1'b1; rdy[0] = 1'b1;
    applyStimulus(7);
    #3;
    applyReset();
    applyStimulus(5);
    checkOutput("t6 restart out", 64'(outA), 64'hA);
    checkOutput("t6 restart steps", 64'(stepsA), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
